// File: rtl/ux607_uart_txctrl.sv
// UART transmit controller: start bit, 8 data bits LSB-first, 1 or 2 stop bits.
// Optional TX watermark interrupt is built in when UX607_UART_TXCTRL_WM_EN is defined.
module ux607_uart_txctrl #(
  parameter int DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_en,
  input  logic             io_nstop,
  input  logic [DIV_W-1:0] io_div,
  input  logic             io_in_valid,
  input  logic [7:0]       io_in_bits,
  output logic             io_in_ready,
  input  logic [3:0]       io_txcnt,
  input  logic [2:0]       io_txwm,
  output logic             io_tx,
  output logic             io_busy,
  output logic             io_ip_txwm
);

  // state | meaning
  // IDLE  | line high, waiting for a pop
  // START | start bit (0)
  // DATA  | 8 data bits, LSB first
  // STOP  | one or two stop bits (1)
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       idx;
  logic [7:0]       data_q;
  logic             nstop_q;
  logic             stop2;
  logic             tx_q;
  logic             pop;
  logic             bit_end;

  // Reset gates ready so nothing is popped while the block is held in reset.
  assign io_in_ready = (state == IDLE) & io_en & ~reset;
  assign pop         = io_in_valid & io_in_ready;
  assign bit_end     = (cnt == '0);
  assign io_tx       = tx_q;
  assign io_busy     = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_q   <= '0;
      idx     <= '0;
      data_q  <= '0;
      nstop_q <= 1'b0;
      stop2   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            data_q  <= io_in_bits;
            div_q   <= io_div;
            nstop_q <= io_nstop;
            cnt     <= io_div;
            idx     <= '0;
            stop2   <= 1'b0;
            tx_q    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= div_q;
            idx   <= '0;
            tx_q  <= data_q[0];
            state <= DATA;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= div_q;
            if (idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              idx  <= idx + 3'd1;
              tx_q <= data_q[idx + 3'd1];
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= div_q;
            if (nstop_q && !stop2) begin
              stop2 <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef UX607_UART_TXCTRL_WM_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) io_ip_txwm <= 1'b0;
    else       io_ip_txwm <= (io_txcnt < {1'b0, io_txwm});
  end
`else
  logic unused_wm;
  assign unused_wm  = ^{io_txcnt, io_txwm};
  assign io_ip_txwm = 1'b0;
`endif

endmodule

// File: tb/tb_ux607_uart_txctrl.sv
// Bench for ux607_uart_txctrl: table frames, hand-written corner sequences and random frames
// checked against a bit-level frame model.
module tb_ux607_uart_txctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_en;
  logic        io_nstop;
  logic [15:0] io_div;
  logic        io_in_valid;
  logic [7:0]  io_in_bits;
  logic        io_in_ready;
  logic [3:0]  io_txcnt;
  logic [2:0]  io_txwm;
  logic        io_tx;
  logic        io_busy;
  logic        io_ip_txwm;

  int tests = 0;
  int failures = 0;
  bit cap[$];
  bit expq[$];

  ux607_uart_txctrl dut (
    .clock       (clock),
    .reset       (reset),
    .io_en       (io_en),
    .io_nstop    (io_nstop),
    .io_div      (io_div),
    .io_in_valid (io_in_valid),
    .io_in_bits  (io_in_bits),
    .io_in_ready (io_in_ready),
    .io_txcnt    (io_txcnt),
    .io_txwm     (io_txwm),
    .io_tx       (io_tx),
    .io_busy     (io_busy),
    .io_ip_txwm  (io_ip_txwm)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  data;
    int          dv;
    logic        ns;
    int          exp_len;
    logic [10:0] exp_bits;  // bit 0 = start bit, in line order
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Line value of frame bit k: start=0, then data LSB first, then stop bits=1.
  function automatic bit model_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    return 1'b1;
  endfunction

  task automatic build_model(input logic [7:0] d, input int dv, input logic ns);
    expq.delete();
    for (int k = 0; k < 10 + int'(ns); k++)
      for (int r = 0; r <= dv; r++) expq.push_back(model_bit(d, k));
  endtask

  task automatic build_table(input logic [10:0] bits, input int dv, input logic ns);
    expq.delete();
    for (int k = 0; k < 10 + int'(ns); k++)
      for (int r = 0; r <= dv; r++) expq.push_back(bits[k]);
  endtask

  task automatic check_frame(input string nm, input int exp_len);
    int errs = 0;
    int n;
    check({nm, "_len"}, cap.size(), exp_len);
    n = (cap.size() < expq.size()) ? cap.size() : expq.size();
    for (int i = 0; i < n; i++) if (cap[i] != expq[i]) errs++;
    check({nm, "_wave"}, errs, 0);
  endtask

  // Waits for ready at a falling edge, presents one byte, returns at the first START cycle.
  task automatic pop_byte(input logic [7:0] d, input logic [15:0] dv, input logic ns);
    int w = 0;
    while (!io_in_ready && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("pop_ready", io_in_ready, 1'b1);
    io_in_bits  = d;
    io_div      = dv;
    io_nstop    = ns;
    io_in_valid = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
  endtask

  // Records io_tx each cycle while busy; optionally perturbs inputs mid-frame.
  task automatic capture(input int chg_cyc, input logic [15:0] chg_div, input logic chg_en,
                         input logic chg_valid, input bit scramble);
    int n = 0;
    cap.delete();
    while (io_busy && n < 4000) begin
      cap.push_back(io_tx);
      if (scramble) begin
        io_div   = 16'($urandom_range(0, 15));
        io_nstop = 1'($urandom_range(0, 1));
      end
      if (n == chg_cyc) begin
        io_div      = chg_div;
        io_en       = chg_en;
        io_in_valid = chg_valid;
      end
      n++;
      @(negedge clock);
    end
    check("capture_bound", (n < 4000), 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int errs;
    vecs[0] = '{8'hA5, 3, 1'b0, 40, {2'b11, 8'hA5, 1'b0}};
    vecs[1] = '{8'h00, 0, 1'b1, 11, {2'b11, 8'h00, 1'b0}};
    vecs[2] = '{8'hFF, 0, 1'b1, 11, {2'b11, 8'hFF, 1'b0}};
    vecs[3] = '{8'h3C, 1, 1'b0, 20, {2'b11, 8'h3C, 1'b0}};
    vecs[4] = '{8'h81, 2, 1'b1, 33, {2'b11, 8'h81, 1'b0}};
    vecs[5] = '{8'h5A, 7, 1'b0, 80, {2'b11, 8'h5A, 1'b0}};

    reset = 1'b1; io_en = 1'b1; io_nstop = 1'b0; io_div = 16'd3;
    io_in_valid = 1'b0; io_in_bits = 8'h00; io_txcnt = 4'd0; io_txwm = 3'd0;
    @(negedge clock);
    @(negedge clock);
    check("rst_tx", io_tx, 1'b1);
    check("rst_busy", io_busy, 1'b0);
    check("rst_ready", io_in_ready, 1'b0);
    check("rst_ip", io_ip_txwm, 1'b0);
    reset = 1'b0;

    // Empty queue: stay idle with line high.
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (io_tx !== 1'b1 || io_busy !== 1'b0 || io_in_ready !== 1'b1) errs++;
    end
    check("idle_empty", errs, 0);

    // Table of single frames.
    foreach (vecs[i]) begin
      pop_byte(vecs[i].data, 16'(vecs[i].dv), vecs[i].ns);
      capture(-1, 16'd0, 1'b1, 1'b0, 1'b0);
      build_table(vecs[i].exp_bits, vecs[i].dv, vecs[i].ns);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_len);
      check($sformatf("vec%0d_idle_tx", i), io_tx, 1'b1);
    end

    // Back-to-back frames with valid held high: exactly one idle cycle between.
    pop_byte(8'h00, 16'd0, 1'b1);
    io_in_valid = 1'b1;
    io_in_bits  = 8'hFF;
    capture(-1, 16'd0, 1'b1, 1'b1, 1'b0);
    build_model(8'h00, 0, 1'b1);
    check_frame("b2b_a", 11);
    check("b2b_gap_busy", io_busy, 1'b0);
    check("b2b_gap_ready", io_in_ready, 1'b1);
    @(negedge clock);
    check("b2b_restart_busy", io_busy, 1'b1);
    io_in_valid = 1'b0;
    capture(-1, 16'd0, 1'b1, 1'b0, 1'b0);
    build_model(8'hFF, 0, 1'b1);
    check_frame("b2b_b", 11);

    // Divisor change mid-DATA only affects the next frame.
    pop_byte(8'h3C, 16'd3, 1'b0);
    capture(12, 16'd7, 1'b1, 1'b0, 1'b0);
    build_model(8'h3C, 3, 1'b0);
    check_frame("divchg_cur", 40);
    pop_byte(8'hC3, 16'd7, 1'b0);
    capture(-1, 16'd0, 1'b1, 1'b0, 1'b0);
    build_model(8'hC3, 7, 1'b0);
    check_frame("divchg_next", 80);

    // Disabled with a non-empty queue.
    io_en = 1'b0; io_in_valid = 1'b1; io_in_bits = 8'h77;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (io_in_ready !== 1'b0 || io_tx !== 1'b1 || io_busy !== 1'b0) errs++;
    end
    check("en_off_hold", errs, 0);
    io_in_valid = 1'b0; io_en = 1'b1;

    // Enable dropped mid-DATA: frame completes, no further pop.
    pop_byte(8'h96, 16'd3, 1'b0);
    capture(15, 16'd3, 1'b0, 1'b1, 1'b0);
    build_model(8'h96, 3, 1'b0);
    check_frame("en_drop", 40);
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      if (io_in_ready !== 1'b0 || io_tx !== 1'b1 || io_busy !== 1'b0) errs++;
      @(negedge clock);
    end
    check("en_drop_no_pop", errs, 0);
    io_in_valid = 1'b0; io_en = 1'b1;

    // Reset in DATA bit 4, then a fresh pop right after release.
    pop_byte(8'h00, 16'd3, 1'b0);
    for (int i = 0; i < 21; i++) @(negedge clock);
    check("prerst_tx", io_tx, 1'b0);
    check("prerst_busy", io_busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_tx", io_tx, 1'b1);
    check("midrst_busy", io_busy, 1'b0);
    check("midrst_ready", io_in_ready, 1'b0);
    check("midrst_ip", io_ip_txwm, 1'b0);
    io_in_valid = 1'b1; io_in_bits = 8'h5A; io_div = 16'd1; io_nstop = 1'b0;
    @(negedge clock);
    check("inrst_busy", io_busy, 1'b0);
    reset = 1'b0;
    #1;
    check("postrst_ready", io_in_ready, 1'b1);
    @(negedge clock);
    io_in_valid = 1'b0;
    check("postrst_pop_busy", io_busy, 1'b1);
    capture(-1, 16'd0, 1'b1, 1'b0, 1'b0);
    build_model(8'h5A, 1, 1'b0);
    check_frame("postrst", 20);

    // Random frames; div/nstop scrambled during each frame.
    for (int f = 0; f < 20; f++) begin
      logic [7:0] d;
      int dv;
      logic ns;
      d  = 8'($urandom);
      dv = int'($urandom_range(0, 4));
      ns = 1'($urandom_range(0, 1));
      pop_byte(d, 16'(dv), ns);
      capture(-1, 16'd0, 1'b1, 1'b0, 1'b1);
      build_model(d, dv, ns);
      check_frame($sformatf("rnd%0d", f), (10 + int'(ns)) * (dv + 1));
    end

`ifdef UX607_UART_TXCTRL_WM_EN
    io_txwm = 3'd4; io_txcnt = 4'd5;
    @(negedge clock);
    @(negedge clock);
    check("wm_above", io_ip_txwm, 1'b0);
    io_txcnt = 4'd3;
    #1;
    check("wm_not_yet", io_ip_txwm, 1'b0);
    @(negedge clock);
    check("wm_rise", io_ip_txwm, 1'b1);
    for (int i = 0; i < 20; i++) begin
      logic [3:0] c;
      logic [2:0] w;
      c = 4'($urandom_range(0, 8));
      w = 3'($urandom);
      io_txcnt = c; io_txwm = w;
      @(negedge clock);
      check($sformatf("wm_rnd%0d", i), io_ip_txwm, (int'(c) < int'(w)) ? 1'b1 : 1'b0);
    end
`else
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      io_txcnt = 4'($urandom_range(0, 8));
      io_txwm  = 3'($urandom);
      @(negedge clock);
      if (io_ip_txwm !== 1'b0) errs++;
    end
    check("wm_disabled", errs, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/ux607_uart_txctrl.md
UX607_UART_TXCTRL -- requirements
Module: ux607_uart_txctrl

Interface
REQ-001 SHALL provide parameter DIV_W, default 16, meaning width of the baud divisor input and the bit-period counter.
REQ-002 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port io_en  input  1  transmit enable; gates new frame starts only.
REQ-005 SHALL have port io_nstop  input  1  stop-bit count select: 0 = one stop bit, 1 = two stop bits.
REQ-006 SHALL have port io_div  input  DIV_W  bit period minus one, in clocks.
REQ-007 SHALL have port io_in_valid  input  1  TX queue dequeue-side valid.
REQ-008 SHALL have port io_in_bits  input  8  TX queue dequeue-side data byte.
REQ-009 SHALL have port io_in_ready  output  1  pop strobe to the TX queue (dequeue-side ready).
REQ-010 SHALL have port io_txcnt  input  4  TX queue occupancy, 0..8.
REQ-011 SHALL have port io_txwm  input  3  TX watermark level.
REQ-012 SHALL have port io_tx  output  1  serial line, idle high.
REQ-013 SHALL have port io_busy  output  1  frame in progress.
REQ-014 SHALL have port io_ip_txwm  output  1  TX watermark interrupt-pending.

Function
REQ-015 SHALL implement the states IDLE, START, DATA and STOP.
REQ-016 SHALL drive io_in_ready = (state==IDLE) & io_en, combinationally.
REQ-017 SHALL treat io_in_valid & io_in_ready in cycle N as a pop: latch io_in_bits, io_div and io_nstop, load the bit counter with the latched io_div, and enter START at edge N+1.
REQ-018 SHALL hold every bit for io_div+1 clocks: the counter decrements each cycle, and the bit ends in the cycle where counter==0, which reloads the counter with the latched div.
REQ-019 SHALL drive io_tx from a register: 0 in START, data LSB-first in DATA (exactly 8 bits, using a 3-bit index), 1 in STOP and IDLE.
REQ-020 SHALL leave STOP for IDLE after 1 stop bit if latched nstop=0, or after 2 stop bits if it is 1.
REQ-021 SHALL make a frame last (10+nstop)*(div+1) clocks, with at least one IDLE cycle between frames.
REQ-022 SHALL ignore changes to io_div and io_nstop during a frame, because only the latched values are used.
REQ-023 SHALL, when io_en falls mid-frame, complete the current frame and pop no new byte.
REQ-024 SHALL, in IDLE with io_in_valid=0 (queue empty), stay in IDLE with io_tx=1.
REQ-025 SHALL, when div=0, hold each bit for exactly one clock.
REQ-026 SHALL drive io_busy = (state != IDLE).

Reset
REQ-027 SHALL, on reset assertion at any time (including mid-frame), immediately force state=IDLE, io_tx=1, counter=0, bit index=0 and latched byte=0.
REQ-028 SHALL drive io_busy=0, io_in_ready=0 and io_ip_txwm=0 while reset is asserted.
REQ-029 SHALL NOT resume an aborted frame after reset; the next frame starts only on a fresh pop.

Configuration
REQ-030 SHALL use the macro UX607_UART_TXCTRL_WM_EN; when it is defined, io_ip_txwm = (io_txcnt < {1'b0,io_txwm}), registered one cycle, reset value 0.
REQ-031 SHALL, when UX607_UART_TXCTRL_WM_EN is undefined, tie io_ip_txwm to 0 and leave io_txcnt and io_txwm unused.

Verification
REQ-032 SHALL verify: div=3, nstop=0, en=1, queue pushes 0xA5 -> pop in the first cycle valid is seen; io_tx sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 clocks; busy for 40 clocks.
REQ-033 SHALL verify: div=0, nstop=1, bytes 0x00 then 0xFF queued -> two frames of 11 clocks each, separated by exactly 1 IDLE cycle; two stop bits observed.
REQ-034 SHALL verify: io_div changed from 3 to 7 during DATA -> the remaining bits of the current frame stay 4 clocks; the next frame uses 8 clocks per bit.
REQ-035 SHALL verify: io_en=0 with a non-empty queue -> io_in_ready=0 and io_tx=1 indefinitely; io_en deasserted in DATA -> that frame completes and there is no further pop.
REQ-036 SHALL verify: reset pulsed in DATA bit 4 -> io_tx=1 and busy=0 immediately; after release with io_in_valid=1, a pop occurs in the first cycle.
REQ-037 SHALL verify, with WM_EN defined: txwm=4, txcnt stepping 5->3 -> io_ip_txwm rises one clock after txcnt=3; with WM_EN undefined it is constant 0.
